instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
Fetch-side initiator that drives the instruction memory read port and hands fetched instructions to decode. It generates the program counter, issues one read address per cycle into a memory with fixed 1-cycle registered read latency, and tracks in-flight reads. Returned words go into a small FIFO so decode backpressure never drops or duplicates an instruction. Branch/jump redirects flush the FIFO and squash any in-flight read.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous active-high reset
o_imem_addr  output  32  byte read address to instruction memory
o_imem_req  output  1  high when o_imem_addr is a real fetch this cycle
i_imem_rdata  input  32  memory read data, valid the cycle after the address was presented
i_redirect  input  1  flush and restart fetch at i_redirect_pc
i_redirect_pc  input  32  redirect target byte address
o_instr_valid  output  1  FIFO head valid
o_instr  output  32  instruction at FIFO head
o_instr_pc  output  32  byte PC of o_instr
i_instr_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (i_rst high at edge): fetch_pc=RESET_PC, FIFO empty, inflight_q=0. o_instr_valid=0, o_instr=0, o_instr_pc=0, o_imem_req=0.
- PC is a byte address and always word-aligned. Sequential increment is +4 and wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
- i_redirect_pc[1:0] is ignored and forced to 2'b00.
- pop = o_instr_valid && i_instr_ready. count = FIFO occupancy.
- Issue condition (no redirect): issue = (count + inflight_q - pop) < FIFO_DEPTH.
  - o_imem_req = issue and o_imem_addr = fetch_pc.
  - On issue: inflight_q<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4. Otherwise inflight_q<=0.
  - When not issuing, o_imem_addr holds fetch_pc. The memory may read it, but the result is ignored.
- Return: if inflight_q is high and there is no redirect, push {inflight_pc, i_imem_rdata} into the FIFO at the edge ending that cycle. The issue rule guarantees this push never overflows.
- Output: o_instr_valid = (count != 0). o_instr and o_instr_pc come from registered FIFO storage, not from i_imem_rdata.
  - While o_instr_valid=1 and i_instr_ready=0, o_instr and o_instr_pc hold stable.
- Latency: an address issued in cycle N is visible on o_instr in cycle N+2 (memory register plus FIFO write).
  - Steady-state throughput is 1 instr/cycle with i_instr_ready held high.
  - First valid appears 2 cycles after the first non-reset edge.
- Redirect (highest priority after reset) in cycle N:
  - FIFO is cleared (count<=0). Any pop that cycle is moot.
  - Read data returning in cycle N is discarded.
  - o_imem_req=1 and o_imem_addr=aligned i_redirect_pc in the same cycle (combinational bypass).
  - At the edge: inflight_q<=1, inflight_pc<=target, fetch_pc<=target+4.
  - Target instruction appears on o_instr in cycle N+2. No pre-redirect PC is ever presented after cycle N.
- Simultaneous push and pop: count unchanged, head advances, new tail written.
- Simultaneous push/pop/issue with FIFO full: legal only per the issue formula; pop frees the slot.
- Back-to-back redirects: the last one wins. Each squashes the previous in-flight read.
- Reset mid-operation: overrides redirect/pop/push. State returns to reset values at that edge, and fetch restarts at RESET_PC.

Test Plan:
1. Memory word at byte addr 4k = 32'hA000_0000+k, reset 3 cycles, ready=1 -> o_instr_valid first high 2 cycles after reset release. Then pc/instr 0/A0000000, 4/A0000001, 8/A0000002 on consecutive cycles, no gaps.
2. Ready low for 6 cycles after 2 instrs accepted -> o_instr_pc held at 8. o_imem_req goes low once count+inflight=2. On release, PCs 8, C, 10, ... follow with no skip or duplicate.
3. FIFO full, i_redirect=1 with pc 32'h40 for 1 cycle -> o_imem_addr=40 that cycle. o_instr_valid low the next cycle. o_instr_pc=40 two cycles after redirect, then 44. No old PC appears.
4. i_redirect_pc=32'h43 -> fetches 40, 44, 48.
5. Reset asserted mid-stream with redirect also high -> next cycle o_instr_valid=0, o_instr=0, o_instr_pc=0. After release, fetch restarts at RESET_PC.
6. RESET_PC=32'hFFFF_FFF8 -> delivered PCs FFFFFFF8, FFFFFFFC, 00000000, 00000004.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: generates the PC, drives a 1-cycle-latency
// instruction memory, and buffers returned words in a small FIFO so decode
// backpressure never loses or repeats an instruction. Redirects flush the
// buffer and squash the read that is in flight.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_req,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_instr_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    // Fetch state
    logic [31:0]   fetchPc_q, fetchPc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflightPc_q, inflightPc_d;

    // Instruction buffer
    logic [31:0]   fifoInstr_q [FIFO_DEPTH];
    logic [31:0]   fifoPc_q    [FIFO_DEPTH];
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occupancy;
    logic [31:0]   redirectTarget;
    logic [1:0]    unusedRedirectLsbs;

    // The low two bits of a redirect target are forced to zero, so they are
    // intentionally left unread.
    assign unusedRedirectLsbs = i_redirect_pc[1:0];
    assign redirectTarget     = {i_redirect_pc[31:2], 2'b00};

    assign pop  = (count_q != '0) && i_instr_ready;
    assign push = inflight_q && !i_redirect;

    // Slots already claimed (buffered plus in flight) minus the one leaving
    // this cycle; a new read is only issued if its data is guaranteed a slot.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    assign issue     = occupancy < (CW+1)'(FIFO_DEPTH);

    // Next-state logic: a redirect overrides normal issue/push/pop and its
    // target is presented to memory in the same cycle.
    always_comb begin
        o_imem_req   = 1'b0;
        o_imem_addr  = fetchPc_q;
        fetchPc_d    = fetchPc_q;
        inflight_d   = 1'b0;
        inflightPc_d = inflightPc_q;
        rdPtr_d      = rdPtr_q;
        wrPtr_d      = wrPtr_q;
        count_d      = count_q;
        if (i_redirect) begin
            o_imem_req   = 1'b1;
            o_imem_addr  = redirectTarget;
            inflight_d   = 1'b1;
            inflightPc_d = redirectTarget;
            fetchPc_d    = redirectTarget + 32'd4;
            rdPtr_d      = '0;
            wrPtr_d      = '0;
            count_d      = '0;
        end else begin
            if (issue) begin
                o_imem_req   = 1'b1;
                inflight_d   = 1'b1;
                inflightPc_d = fetchPc_q;
                fetchPc_d    = fetchPc_q + 32'd4;
            end
            if (push) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
        if (i_rst) begin
            o_imem_req = 1'b0;
        end
    end

    // State registers and buffer storage, synchronous reset clears everything
    // so the head reads as zero until the first instruction arrives.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetchPc_q    <= RESET_PC;
            inflight_q   <= 1'b0;
            inflightPc_q <= '0;
            rdPtr_q      <= '0;
            wrPtr_q      <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoInstr_q[i] <= '0;
                fifoPc_q[i]    <= '0;
            end
        end else begin
            fetchPc_q    <= fetchPc_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            count_q      <= count_d;
            if (push) begin
                fifoInstr_q[wrPtr_q] <= i_imem_rdata;
                fifoPc_q[wrPtr_q]    <= inflightPc_q;
            end
        end
    end

    assign o_instr_valid = (count_q != '0);
    assign o_instr       = fifoInstr_q[rdPtr_q];
    assign o_instr_pc    = fifoPc_q[rdPtr_q];

endmodule
